// File: rtl/dcm_lock_ctrl.sv
// rtl/dcm_lock_ctrl.sv - DCM reset sequencer and lock supervisor for clk200
// Runs in the fclk domain; only ready releases downstream clk200 logic.
module dcm_lock_ctrl #(
  parameter int RST_CYCLES    = 4,
  parameter int LOCK_TIMEOUT  = 100000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       fclk,
  input  logic       rst,
  input  logic       locked,
  input  logic       retry_req,
  output logic       dcm_rst,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt,
  output logic [7:0] relock_cnt,
  output logic [2:0] state
);

  localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CMAX   = (CMAX_A > STABLE_CYCLES) ? CMAX_A : STABLE_CYCLES;
  localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t        cur, nxt;
  logic          sync1, locked_s;
  logic [CW-1:0] cnt;
  logic          retry_inc, retry_clr, relock_ev;

  always_comb begin
    nxt       = cur;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    relock_ev = 1'b0;
    case (cur)
      S_RESET: if (cnt == RST_LAST) nxt = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        // a lock seen in the timeout cycle still wins
        if (locked_s) begin
          nxt = S_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_inc = 1'b1;
          nxt = (retry_cnt + 4'd1 == MAX_R) ? S_FAIL : S_RESET;
        end
      end
      S_STABLE: begin
        if (!locked_s) begin
          nxt = S_RESET;
        end else if (cnt == STABLE_LAST) begin
          nxt       = S_RUN;
          retry_clr = 1'b1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          relock_ev = 1'b1;
          nxt       = S_RESET;
        end
      end
      S_FAIL: begin
        if (retry_req) begin
          retry_clr = 1'b1;
          nxt       = S_RESET;
        end
      end
      default: nxt = S_RESET;
    endcase
  end

  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      sync1      <= 1'b0;
      locked_s   <= 1'b0;
      cur        <= S_RESET;
      cnt        <= '0;
      retry_cnt  <= 4'd0;
      relock_cnt <= 8'd0;
      lock_lost  <= 1'b0;
      dcm_rst    <= 1'b1;
      ready      <= 1'b0;
      fail       <= 1'b0;
    end else begin
      sync1    <= locked;
      locked_s <= sync1;
      cur      <= nxt;
      // cnt may wrap in RUN/FAIL, where it is never compared
      cnt      <= (nxt != cur) ? '0 : cnt + CW'(1);
      if (retry_clr)      retry_cnt <= 4'd0;
      else if (retry_inc) retry_cnt <= retry_cnt + 4'd1;
      if (relock_ev) begin
        lock_lost <= 1'b1;
        if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
      end
      dcm_rst <= (nxt == S_RESET) || (nxt == S_FAIL);
      ready   <= (nxt == S_RUN);
      fail    <= (nxt == S_FAIL);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_dcm_lock_ctrl.sv
// tb/tb_dcm_lock_ctrl.sv - self-checking bench for dcm_lock_ctrl
// Reference model tracks phase entry times and a delayed-lock queue.
module tb_dcm_lock_ctrl;

  localparam int RST  = 4;
  localparam int TO   = 50;
  localparam int STAB = 8;
  localparam int MAXR = 2;

  localparam int P_RESET = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       fclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       retry_req = 1'b0;
  logic       dcm_rst, ready, fail, lock_lost;
  logic [3:0] retry_cnt;
  logic [7:0] relock_cnt;
  logic [2:0] state;

  dcm_lock_ctrl #(
    .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STAB), .MAX_RETRIES(MAXR)
  ) dut (
    .fclk(fclk), .rst(rst), .locked(locked), .retry_req(retry_req),
    .dcm_rst(dcm_rst), .ready(ready), .fail(fail), .lock_lost(lock_lost),
    .retry_cnt(retry_cnt), .relock_cnt(relock_cnt), .state(state)
  );

  always #5 fclk = ~fclk;

  int checks = 0;
  int errors = 0;
  int n, hold;

  int m_phase, m_enter, m_cyc, m_retries, m_relocks;
  bit m_lost;
  bit lq[$];

  function automatic void model_reset();
    m_phase = P_RESET; m_enter = 0; m_cyc = 0;
    m_retries = 0; m_relocks = 0; m_lost = 0;
    lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
  endfunction

  // lock value acted on at an edge is the one sampled two edges earlier
  function automatic void model_edge(bit lk, bit rr);
    bit ls;
    int nxt;
    m_cyc++;
    ls = lq.pop_front();
    lq.push_back(lk);
    nxt = m_phase;
    case (m_phase)
      P_RESET: if (m_cyc == m_enter + RST) nxt = P_WAIT;
      P_WAIT: begin
        if (ls) nxt = P_STABLE;
        else if (m_cyc == m_enter + TO) begin
          m_retries++;
          nxt = (m_retries == MAXR) ? P_FAIL : P_RESET;
        end
      end
      P_STABLE: begin
        if (!ls) nxt = P_RESET;
        else if (m_cyc == m_enter + STAB) begin nxt = P_RUN; m_retries = 0; end
      end
      P_RUN: if (!ls) begin
        m_lost = 1;
        if (m_relocks < 255) m_relocks++;
        nxt = P_RESET;
      end
      default: if (rr) begin m_retries = 0; nxt = P_RESET; end
    endcase
    if (nxt != m_phase) begin m_phase = nxt; m_enter = m_cyc; end
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge fclk);
    if (rst) model_reset();
    else model_edge(locked, retry_req);
    @(negedge fclk);
    check("state",      16'(state),      16'(m_phase));
    check("dcm_rst",    16'(dcm_rst),    16'(m_phase == P_RESET || m_phase == P_FAIL));
    check("ready",      16'(ready),      16'(m_phase == P_RUN));
    check("fail",       16'(fail),       16'(m_phase == P_FAIL));
    check("lock_lost",  16'(lock_lost),  16'(m_lost));
    check("retry_cnt",  16'(retry_cnt),  16'(m_retries));
    check("relock_cnt", 16'(relock_cnt), 16'(m_relocks));
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    ticks(3);
    check("reset_dcm_rst", 16'(dcm_rst), 16'd1);
    check("reset_state", 16'(state), 16'd0);
    rst = 1'b0;

    // nominal lock
    n = 0;
    do begin tick(); n++; end while (dcm_rst !== 1'b0 && n < 20);
    check("rst_width", 16'(n), 16'(RST));
    ticks(16);
    locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 40);
    check("lock_to_ready", 16'(n), 16'(3 + STAB));
    check("nominal_retry", 16'(retry_cnt), 16'd0);
    check("nominal_fail", 16'(fail), 16'd0);

    // loss of lock in RUN, then relock
    ticks(5);
    locked = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b0 && n < 20);
    check("loss_to_drop", 16'(n), 16'd3);
    check("loss_dcm_rst", 16'(dcm_rst), 16'd1);
    check("loss_flag", 16'(lock_lost), 16'd1);
    check("loss_relock", 16'(relock_cnt), 16'd1);
    ticks(10);
    locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 40);
    check("relock_latency", 16'(n), 16'(3 + STAB));
    check("relock_flag_sticky", 16'(lock_lost), 16'd1);

    // glitch during STABLE
    locked = 1'b0;
    rst_pulse();
    ticks(6);
    locked = 1'b1;
    ticks(5);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    do begin tick(); n++; end while (dcm_rst !== 1'b1 && n < 10);
    n = 0;
    do begin tick(); n++; end while (dcm_rst !== 1'b0 && n < 20);
    check("glitch_rst_width", 16'(n), 16'(RST));
    check("glitch_retry", 16'(retry_cnt), 16'd0);
    n = 0;
    do begin tick(); n++; end while (ready !== 1'b1 && n < 40);
    check("glitch_ready", 16'(ready), 16'd1);

    // timeout, fail, retry
    locked = 1'b0;
    rst_pulse();
    ticks(RST + TO);
    check("timeout_retry1", 16'(retry_cnt), 16'd1);
    check("timeout_restart", 16'(state), 16'(P_RESET));
    ticks(RST + TO);
    check("fail_state", 16'(state), 16'(P_FAIL));
    check("fail_flag", 16'(fail), 16'd1);
    check("fail_dcm_rst", 16'(dcm_rst), 16'd1);
    locked = 1'b1;
    ticks(6);
    locked = 1'b0;
    ticks(2);
    retry_req = 1'b1;
    tick();
    retry_req = 1'b0;
    check("retry_clear", 16'(retry_cnt), 16'd0);
    check("retry_restart", 16'(state), 16'(P_RESET));
    check("retry_dcm_rst", 16'(dcm_rst), 16'd1);
    ticks(3);

    // lock and timeout in the same cycle
    rst_pulse();
    ticks(RST + TO - 3);
    locked = 1'b1;
    ticks(3);
    check("lock_beats_timeout", 16'(state), 16'(P_STABLE));
    check("lock_beats_retry", 16'(retry_cnt), 16'd0);

    // asynchronous reset mid-STABLE
    ticks(2);
    #2 rst = 1'b1;
    #1;
    check("async_dcm_rst", 16'(dcm_rst), 16'd1);
    check("async_ready", 16'(ready), 16'd0);
    check("async_state", 16'(state), 16'd0);
    check("async_counts", 16'({retry_cnt, relock_cnt}), 16'd0);
    tick();
    rst = 1'b0;

    // randomized lock behaviour and retry pulses
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        locked = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 30);
      end
      hold--;
      retry_req = ($urandom_range(0, 9) == 0);
      tick();
    end
    retry_req = 1'b0;

    // relock counter saturation
    locked = 1'b0;
    rst_pulse();
    for (int i = 0; i < 260; i++) begin
      locked = 1'b1;
      ticks(14);
      locked = 1'b0;
      ticks(8);
    end
    check("relock_saturate", 16'(relock_cnt), 16'd255);
    check("relock_flag", 16'(lock_lost), 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcm_lock_ctrl.md
# dcm_lock_ctrl

Reset sequencer and lock supervisor for the DVI clock-generation DCM that produces clk200 from the 100 MHz input clock fclk. It drives the DCM's reset pin, waits for LOCKED with a timeout and bounded retries, and debounces LOCKED before asserting a clean ready. After ready is up, it detects loss of lock and relocks automatically. It runs entirely in the fclk domain and sits between the board reset and the DCM wrapper; downstream clk200 logic is released only by its ready output.

## Interface

Parameters:
- RST_CYCLES, default 4: fclk cycles dcm_rst is held high per attempt. Must be at least 3, the DCM minimum reset width.
- LOCK_TIMEOUT, default 100000: fclk cycles to wait for lock per attempt (1 ms at 100 MHz).
- STABLE_CYCLES, default 1024: consecutive fclk cycles synchronized lock must stay high before ready asserts.
- MAX_RETRIES, default 7: number of timed-out attempts before giving up.

Ports:
- fclk, input, 1: free-running input clock, the only clock.
- rst, input, 1: asynchronous, active-high reset.
- locked, input, 1: DCM LOCKED. Treated as asynchronous and passed through a 2-flop synchronizer; the synchronized value is locked_s.
- retry_req, input, 1: single-cycle pulse that leaves FAIL and restarts the sequence. Ignored in every other state.
- dcm_rst, output, 1: DCM reset, registered.
- ready, output, 1: clk200 is usable, registered.
- fail, output, 1: retries are exhausted, registered.
- lock_lost, output, 1: sticky flag; set whenever lock drops while in RUN.
- retry_cnt, output, 4: timeouts in the current sequence.
- relock_cnt, output, 8: RUN-to-RESET transitions. Saturates at 255.
- state, output, 3: FSM state for debug. Encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.

## Operation

While rst is high, all outputs and state hold their reset values:
- state=RESET, dcm_rst=1, ready=0, fail=0, lock_lost=0.
- retry_cnt=0, relock_cnt=0.
- Synchronizer flops=0, all counters=0.

FSM, with one shared cycle counter cnt that clears on every state change:
- RESET: dcm_rst=1. When cnt=RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: dcm_rst=0.
  - If locked_s=1, go to STABLE.
  - Otherwise, if cnt=LOCK_TIMEOUT-1: increment retry_cnt. Go to FAIL if the new value equals MAX_RETRIES, else go to RESET.
  - Lock takes priority over timeout in the same cycle.
- STABLE: dcm_rst=0.
  - If locked_s=0, go to RESET. retry_cnt is unchanged; this glitch is not counted as a retry.
  - If locked_s=1 and cnt=STABLE_CYCLES-1, go to RUN and clear retry_cnt.
- RUN: ready=1. If locked_s=0: set lock_lost, increment relock_cnt (saturating), and go to RESET.
- FAIL: dcm_rst=1, fail=1. On retry_req=1, clear retry_cnt and go to RESET. lock_lost and relock_cnt are unaffected.

Register and output rules:
- ready, dcm_rst and fail are registered decodes of the next state. Each output therefore changes on the same edge as the state register.
- lock_lost clears only on rst.
- relock_cnt holds at 255 once it saturates.
- Counters are sized with $clog2 of the largest compare value. A compare value of 0 or 1 must still work; for example, STABLE_CYCLES=1 means RUN is entered on the first cycle locked_s=1 is seen in STABLE.
- The locked input is ignored in RESET and FAIL, apart from continuing to shift through the synchronizer.

## Timing

- After rst deasserts, dcm_rst stays high for exactly RST_CYCLES fclk rising edges, then falls.
- locked to locked_s latency: 2 cycles.
- Lock to ready: ready rises 2 + 1 + STABLE_CYCLES cycles after locked rises (synchronizer, entry into STABLE, then the dwell), provided locked stays high throughout.
- Loss of lock: ready falls, dcm_rst rises and lock_lost sets 3 cycles after locked falls (2 synchronizer cycles plus 1 register).
- Timeout: the WAIT_LOCK-to-RESET transition occurs LOCK_TIMEOUT cycles after WAIT_LOCK is entered.
- retry_req to dcm_rst: dcm_rst stays high through the FAIL-to-RESET transition, so there is no gap in DCM reset.
- rst asserted mid-operation, in any state: all outputs asynchronously return to their reset values, and dcm_rst asserts immediately.
- ready is never high at the same time as dcm_rst or fail.

## Test plan

All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, MAX_RETRIES=2.

- Nominal lock: release rst, drive locked=1 20 cycles later. Expect:
  - dcm_rst high for 4 cycles after release.
  - ready rises exactly 11 cycles after locked rises.
  - retry_cnt=0, fail=0.
- Glitch during STABLE: locked high for 5 cycles, low for 1 cycle, then high. Expect:
  - A return to RESET with a 4-cycle dcm_rst pulse.
  - retry_cnt stays 0.
  - ready rises 11 cycles after the final locked rise, measured once WAIT_LOCK is re-entered.
- Timeout and fail: keep locked=0. Expect:
  - retry_cnt goes to 1 after the first 50-cycle wait, then the sequence restarts.
  - After the second wait, state=FAIL, fail=1, dcm_rst=1.
  - A retry_req pulse clears retry_cnt and restarts, with dcm_rst held high continuously.
- Loss of lock in RUN: reach RUN, then drop locked. Expect:
  - ready falls 3 cycles after locked falls; lock_lost=1, relock_cnt=1.
  - The sequence relocks when locked returns; lock_lost stays 1.
- Relock saturation: force 256 lock losses. Expect relock_cnt=255, not 0.
- Asynchronous reset: assert rst mid-STABLE, between clock edges. Expect:
  - dcm_rst=1, ready=0 and state=0 before the next edge.
  - All counters zero.
  - Simultaneous lock and timeout in WAIT_LOCK resolves to STABLE.
